// File: rtl/feistel_decrypt.sv
// ----------------------------------------------------------------------------
// feistel_decrypt
//
// Five-round Feistel block decryptor with a serially loaded 256-entry S-box.
// Undoes a Feistel encryptor that runs (L,R) <= (R, L ^ F(R,K)) with keys
// K0..K4 and no final swap, by running (L,R) <= (R ^ F(L,K), L) with keys
// K4..K0.
//
// Round function F(X,K): byte j of the result is SBOX[X byte j ^ K byte j].
// Its result becomes usable F_LAT cycles after its inputs change, so one round
// takes F_LAT cycles.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   sbox_out     S-box load byte; the n-th qualified byte fills entry n
//   sbox_valid   qualifier for sbox_out (ignored once all 256 entries loaded)
//   K0..K4       round keys, sampled every round; hold stable while busy
//   tvalid       ciphertext strobe, taken only while tready is high
//   ciphertext   block to decrypt, {L, R}
//   tready       high only while idle and ready to take a block
//   valid        one-cycle strobe marking a new plaintext
//   plaintext    decrypted block {L, R}, held until the next valid
//   err          (only with FEISTEL_DEC_ERR_EN) one-cycle pulse when tvalid
//                arrives while tready is low, or sbox_valid arrives after the
//                S-box is full
//
// Optional feature macro: FEISTEL_DEC_ERR_EN adds the err output.
// ----------------------------------------------------------------------------
module feistel_decrypt #(
    parameter int ROUND      = 5,
    parameter int F_LAT      = 6,
    parameter int SBOX_WIDTH = 8,
    parameter int KEY_SIZE   = 128,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SBOX_WIDTH-1:0] sbox_out,
    input  logic                  sbox_valid,
    input  logic [KEY_SIZE-1:0]   K0,
    input  logic [KEY_SIZE-1:0]   K1,
    input  logic [KEY_SIZE-1:0]   K2,
    input  logic [KEY_SIZE-1:0]   K3,
    input  logic [KEY_SIZE-1:0]   K4,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] ciphertext,
    output logic                  tready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] plaintext
`ifdef FEISTEL_DEC_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int NBYTES = KEY_SIZE / 8;
    localparam int CW     = (F_LAT > 1) ? $clog2(F_LAT) : 1;

    typedef enum logic [1:0] {
        LOAD,
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state;
    logic [7:0]            load_cnt;
    logic                  sbox_ready;
    logic [KEY_SIZE-1:0]   left;
    logic [KEY_SIZE-1:0]   right;
    // Five key ports exist, so three bits always cover the round index.
    logic [2:0]            round_idx;
    logic [CW-1:0]         lat_cnt;

    logic [SBOX_WIDTH-1:0] sbox_mem [256];
    logic                  sbox_we;
    logic [KEY_SIZE-1:0]   round_key;
    logic [KEY_SIZE-1:0]   f_comb;
    logic [KEY_SIZE-1:0]   f_result;
    logic [KEY_SIZE-1:0]   new_left;

    assign sbox_we = reset_n && sbox_valid && !sbox_ready;

    // S-box storage is left uninitialised on reset; the load counter restarts
    // at zero after reset, so a full reload overwrites every entry before use.
    always_ff @(posedge clk) begin
        if (sbox_we) begin
            sbox_mem[load_cnt] <= sbox_out;
        end
    end

    always_comb begin
        round_key = K0;
        case (round_idx)
            3'd0:    round_key = K0;
            3'd1:    round_key = K1;
            3'd2:    round_key = K2;
            3'd3:    round_key = K3;
            3'd4:    round_key = K4;
            default: round_key = K0;
        endcase
    end

    always_comb begin
        f_comb = '0;
        for (int j = 0; j < NBYTES; j++) begin
            f_comb[8*j +: 8] = sbox_mem[left[8*j +: 8] ^ round_key[8*j +: 8]];
        end
    end

    // F_LAT-1 register stages behind the S-box lookup; the round update edge
    // itself is the F_LAT-th cycle, so the total delay from L to use is F_LAT.
    generate
        if (F_LAT > 1) begin : g_f_pipe
            logic [KEY_SIZE-1:0] pipe [F_LAT-1];

            always_ff @(posedge clk) begin
                pipe[0] <= f_comb;
                for (int k = 1; k < F_LAT - 1; k++) begin
                    pipe[k] <= pipe[k-1];
                end
            end

            assign f_result = pipe[F_LAT-2];
        end else begin : g_f_comb
            assign f_result = f_comb;
        end
    endgenerate

    assign new_left = right ^ f_result;

    // Control FSM: LOAD fills the S-box, IDLE offers tready, RUN steps the
    // rounds every F_LAT cycles, DONE is the single cycle where valid is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LOAD;
            load_cnt   <= '0;
            sbox_ready <= 1'b0;
            tready     <= 1'b0;
            valid      <= 1'b0;
            plaintext  <= '0;
            round_idx  <= '0;
            lat_cnt    <= '0;
            left       <= '0;
            right      <= '0;
        end else begin
            valid <= 1'b0;

            if (sbox_we) begin
                load_cnt <= load_cnt + 8'd1;
                if (load_cnt == 8'hFF) begin
                    sbox_ready <= 1'b1;
                end
            end

            case (state)
                LOAD: begin
                    // Leave on the same edge that writes the last entry.
                    if (sbox_we && load_cnt == 8'hFF) begin
                        state  <= IDLE;
                        tready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (tvalid) begin
                        left      <= ciphertext[DATA_WIDTH-1 -: KEY_SIZE];
                        right     <= ciphertext[KEY_SIZE-1:0];
                        round_idx <= 3'(ROUND - 1);
                        lat_cnt   <= '0;
                        tready    <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (lat_cnt == CW'(F_LAT - 1)) begin
                        lat_cnt <= '0;
                        left    <= new_left;
                        right   <= left;
                        if (round_idx == 3'd0) begin
                            plaintext <= {new_left, left};
                            valid     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            round_idx <= round_idx - 3'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    tready <= 1'b1;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

`ifdef FEISTEL_DEC_ERR_EN
    // Flags traffic the block is dropping: a block offered while busy or
    // loading, or S-box bytes arriving after the table is complete.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else begin
            err <= (tvalid && !tready) || (sbox_valid && sbox_ready);
        end
    end
`endif

endmodule

// File: tb/tb_feistel_decrypt.sv
// ----------------------------------------------------------------------------
// tb_feistel_decrypt
//
// Directed bench for feistel_decrypt. Inputs are driven on the falling edge
// and outputs sampled on the falling edge. Latency is counted with the cycle
// that presents the accepted block as cycle 0, so the result is expected in
// cycle 31 and back-to-back results 32 cycles apart.
// Build with FEISTEL_DEC_ERR_EN defined to also check the err output.
// ----------------------------------------------------------------------------
module tb_feistel_decrypt;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   sbox_out;
    logic         sbox_valid;
    logic [127:0] key_arr [5];
    logic         tvalid;
    logic [255:0] ciphertext;
    logic         tready;
    logic         valid;
    logic [255:0] plaintext;
`ifdef FEISTEL_DEC_ERR_EN
    logic         err;
`endif

    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    int           valid_count = 0;
    bit           err_seen = 1'b0;
    logic [7:0]   sbox_model [256];

    feistel_decrypt dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sbox_out   (sbox_out),
        .sbox_valid (sbox_valid),
        .K0         (key_arr[0]),
        .K1         (key_arr[1]),
        .K2         (key_arr[2]),
        .K3         (key_arr[3]),
        .K4         (key_arr[4]),
        .tvalid     (tvalid),
        .ciphertext (ciphertext),
        .tready     (tready),
        .valid      (valid),
        .plaintext  (plaintext)
`ifdef FEISTEL_DEC_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_count++;
`ifdef FEISTEL_DEC_ERR_EN
        if (err === 1'b1) err_seen = 1'b1;
`endif
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h required %0h", tag, got, exp);
        end
    endtask

    // Encryptor reference: (L,R) <= (R, L ^ F(R,K)) with keys K0..K4.
    function automatic logic [127:0] f_model(input logic [127:0] x, input logic [127:0] k);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = sbox_model[x[8*j +: 8] ^ k[8*j +: 8]];
        return r;
    endfunction

    function automatic logic [255:0] encrypt(input logic [255:0] pt);
        logic [127:0] l, r, t;
        l = pt[255:128];
        r = pt[127:0];
        for (int rnd = 0; rnd < 5; rnd++) begin
            t = l ^ f_model(r, key_arr[rnd]);
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    // mode 0: identity table, mode 1: entry k = 255-k
    task automatic load_sbox(input int mode, input int first, input int count);
        logic [7:0] v;
        for (int n = first; n < first + count; n++) begin
            @(negedge clk);
            v = (mode == 0) ? 8'(n) : 8'(255 - n);
            sbox_valid = 1'b1;
            sbox_out = v;
            sbox_model[n] = v;
        end
        @(negedge clk);
        sbox_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [255:0] ct, output logic [255:0] pt, output int lat);
        int n;
        int accept_edge;
        pt = '0;
        lat = -1;
        @(negedge clk);
        ciphertext = ct;
        tvalid = 1'b1;
        n = 0;
        while (tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (tready !== 1'b1) begin
            checkOutput("accept_timeout", 256'(tready), 256'd1);
            tvalid = 1'b0;
            return;
        end
        accept_edge = cyc + 1;
        @(negedge clk);
        tvalid = 1'b0;
        checkOutput("tready_run", 256'(tready), 256'd0);
        n = 0;
        while (valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (valid !== 1'b1) begin
            checkOutput("valid_timeout", 256'(valid), 256'd1);
            return;
        end
        lat = cyc - accept_edge + 1;
        pt = plaintext;
        @(negedge clk);
        checkOutput("valid_pulse", 256'(valid), 256'd0);
    endtask

    localparam logic [255:0] CT_A = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0};
    localparam logic [255:0] PT_A = {128'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    localparam logic [255:0] CT_B = {128'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    localparam logic [255:0] PT_B = {256{1'b1}};
    localparam logic [255:0] ORIG =
        256'h11223344556677889900AABBCCDDEEFF_00112233445566778899AABBCCDDEEFF;

    initial begin
        logic [255:0] pt, pt1, pt2, ct;
        int           lat, n, v1, v2, snap;

        reset_n = 1'b0;
        sbox_out = '0;
        sbox_valid = 1'b0;
        tvalid = 1'b0;
        ciphertext = '0;
        for (int k = 0; k < 5; k++) key_arr[k] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_tready", 256'(tready), 256'd0);
        checkOutput("reset_valid", 256'(valid), 256'd0);
        checkOutput("reset_plaintext", plaintext, 256'd0);

        // Block offered part-way through the S-box load must be dropped.
        load_sbox(0, 0, 100);
        ciphertext = CT_A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tvalid = 1'b1;
            checkOutput("tready_load", 256'(tready), 256'd0);
        end
        @(negedge clk);
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("valid_during_load", 256'(valid_count), 256'd0);
`ifdef FEISTEL_DEC_ERR_EN
        checkOutput("err_during_load", 256'(err_seen), 256'd1);
`endif
        load_sbox(0, 100, 156);
        checkOutput("tready_after_load", 256'(tready), 256'd1);
        $display("[TB] identity S-box loaded");

        // Identity S-box, zero keys.
        applyStimulus(CT_A, pt, lat);
        checkOutput("identity_plaintext", pt, PT_A);
        checkOutput("identity_latency", 256'(lat), 256'd31);

        // 257th byte must not disturb the table.
        err_seen = 1'b0;
        @(negedge clk);
        sbox_valid = 1'b1;
        sbox_out = 8'hA5;
        @(negedge clk);
        sbox_valid = 1'b0;
        repeat (2) @(negedge clk);
`ifdef FEISTEL_DEC_ERR_EN
        checkOutput("err_extra_byte", 256'(err_seen), 256'd1);
`endif
        applyStimulus(CT_A, pt, lat);
        checkOutput("rerun_plaintext", pt, PT_A);
        checkOutput("rerun_latency", 256'(lat), 256'd31);

        // tvalid held high across two blocks.
        @(negedge clk);
        ciphertext = CT_A;
        tvalid = 1'b1;
        n = 0;
        while (tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ciphertext = CT_B;
        n = 0;
        while (valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        v1 = cyc;
        pt1 = plaintext;
        @(negedge clk);
        n = 0;
        while (valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        v2 = cyc;
        pt2 = plaintext;
        tvalid = 1'b0;
        checkOutput("b2b_first_plaintext", pt1, PT_A);
        checkOutput("b2b_second_plaintext", pt2, PT_B);
        checkOutput("b2b_spacing", 256'(v2 - v1), 256'd32);
        repeat (3) @(negedge clk);

        // Reset in the middle of a run.
        @(negedge clk);
        ciphertext = CT_A;
        tvalid = 1'b1;
        n = 0;
        while (tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tvalid = 1'b0;
        repeat (9) @(negedge clk);
        snap = valid_count;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("valid_after_abort", 256'(valid_count), 256'(snap));
        checkOutput("tready_after_abort", 256'(tready), 256'd0);
        load_sbox(1, 0, 255);
        checkOutput("tready_255_bytes", 256'(tready), 256'd0);
        load_sbox(1, 255, 1);
        checkOutput("tready_256_bytes", 256'(tready), 256'd1);
        $display("[TB] inverted S-box loaded");

        // Round trip through the reference encryptor.
        for (int k = 0; k < 5; k++)
            for (int b = 0; b < 16; b++)
                key_arr[k][8*(15-b) +: 8] = 8'(16*k + b);
        ct = encrypt(ORIG);
        applyStimulus(ct, pt, lat);
        checkOutput("roundtrip_plaintext", pt, ORIG);
        checkOutput("roundtrip_latency", 256'(lat), 256'd31);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
